// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - integer register-file write-port arbiter with busy scoreboard
// Pipeline writes always win; mul/div and FPU share the leftover slots round-robin.
module rf_wb_arbiter #(
  parameter int NREG         = 32,
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            pipe_we_i,
  input  logic [4:0]      pipe_waddr_i,
  input  logic [XLEN-1:0] pipe_wdata_i,
  input  logic            md_valid_i,
  input  logic [4:0]      md_waddr_i,
  input  logic [XLEN-1:0] md_wdata_i,
  output logic            md_ready_o,
  input  logic            fp_valid_i,
  input  logic [4:0]      fp_waddr_i,
  input  logic [XLEN-1:0] fp_wdata_i,
  output logic            fp_ready_o,
  input  logic            sb_set_i,
  input  logic [4:0]      sb_addr_i,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            rs1_used_i,
  input  logic            rs2_used_i,
  input  logic            rd_used_i,
  output logic            hazard_o,
  output logic            wb_hold_o,
  output logic            reg_write_o,
  output logic [4:0]      waddr_o,
  output logic [XLEN-1:0] wdata_o
);

  typedef enum logic {GRANT_MD = 1'b0, GRANT_FP = 1'b1} grant_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  grant_e          last_grant_q, last_grant_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic [3:0]      starve_q, starve_d;

  logic claim;
  logic md_grant;
  logic fp_grant;

  assign claim      = pipe_we_i && (pipe_waddr_i != 5'd0);
  // Ready is offered without looking at the requester's own valid.
  assign md_ready_o = !claim && (!fp_valid_i || (last_grant_q == GRANT_FP));
  assign fp_ready_o = !claim && (!md_valid_i || (last_grant_q == GRANT_MD));
  assign md_grant   = md_ready_o && md_valid_i;
  assign fp_grant   = fp_ready_o && fp_valid_i;

  always_comb begin
    reg_write_o = 1'b0;
    waddr_o     = 5'd0;
    wdata_o     = '0;
    if (claim) begin
      reg_write_o = 1'b1;
      waddr_o     = pipe_waddr_i;
      wdata_o     = pipe_wdata_i;
    end else if (md_grant && (md_waddr_i != 5'd0)) begin
      reg_write_o = 1'b1;
      waddr_o     = md_waddr_i;
      wdata_o     = md_wdata_i;
    end else if (fp_grant && (fp_waddr_i != 5'd0)) begin
      reg_write_o = 1'b1;
      waddr_o     = fp_waddr_i;
      wdata_o     = fp_wdata_i;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (md_grant) busy_d[md_waddr_i] = 1'b0;
    if (fp_grant) busy_d[fp_waddr_i] = 1'b0;
    // Applied after the clears so a same-edge set survives.
    if (sb_set_i) busy_d[sb_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (md_grant) last_grant_d = GRANT_MD;
    else if (fp_grant) last_grant_d = GRANT_FP;
  end

  always_comb begin
    starve_d = starve_q;
    if (md_grant || fp_grant || !(md_valid_i || fp_valid_i)) starve_d = 4'd0;
    else if (starve_q < LIMIT) starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_q       <= '0;
      last_grant_q <= GRANT_FP;
      starve_q     <= 4'd0;
    end else begin
      busy_q       <= busy_d;
      last_grant_q <= last_grant_d;
      starve_q     <= starve_d;
    end
  end

  assign hazard_o  = !reset_i && ((rs1_used_i && busy_q[rs1_addr_i]) ||
                                  (rs2_used_i && busy_q[rs2_addr_i]) ||
                                  (rd_used_i  && busy_q[rd_addr_i]));
  assign wb_hold_o = !reset_i && (starve_q == LIMIT);

endmodule
